cmd_queue_axil_initiator: RTL and testbench
===========================================

Name: cmd_queue_axil_initiator

Overview:
AXI4-Lite master that executes single-beat register reads/writes from a simple valid/ready request port. It is the initiator side of the command queue's SQ/CQ AXI4-Lite register ports. Used by the producer/consumer agents to ring doorbells, read pointers and clear interrupts on cmd_queue_v2_0_0_top. One transaction is outstanding at a time, with in-order responses.

Parameters:
C_ADDR_WIDTH, 12, AXI address width; matches C_S00_ADDR_WIDTH/C_S01_ADDR_WIDTH of the target.
C_TIMEOUT_CYCLES, 1024, response-wait limit. Used only with CMD_QUEUE_AXIL_TIMEOUT_EN. Must be ≥2.

Ports:
aclk  in  1  clock
aresetn  in  1  reset; one clock; asynchronous, active-low
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid&req_ready
req_write  in  1  1=write, 0=read
req_addr  in  C_ADDR_WIDTH  byte address; bits[1:0] ignored and driven 0 on AXI
req_wdata  in  32  write data
req_wstrb  in  4  write strobes
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
rsp_rdata  out  32  read data; 0 for writes
rsp_resp  out  2  AXI resp (bresp or rresp)
rsp_timeout  out  1  response was synthesised by timeout; tied 0 without the macro
m_axi_awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready  standard AXI4-Lite master, 32-bit data, 3-bit awprot/arprot tied 3'b000

Behaviour:
- Reset (async assert, sync deassert): FSM=IDLE. All outputs 0 except req_ready=1. Captured registers clear. An in-flight transaction is abandoned and no response is produced.
- All AXI and rsp outputs are driven from registers.
- FSM states: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE: req_ready=1. On handshake, capture the fields and set req_ready=0.
  - Write: next state WR_ADDR; awvalid=wvalid=1 the following cycle.
  - Read: next state RD_ADDR; arvalid=1 the following cycle.
  - Request-to-AXI-valid latency is 1 cycle.
- WR_ADDR:
  - awvalid and wvalid are independent. Each drops the cycle after its own ready is seen, tracked by aw_done and w_done.
  - When both are done (same cycle or different cycles), go to WR_RESP with bready=1.
- WR_RESP: on bvalid&bready, latch bresp, set rsp_rdata=0, bready=0, go to RSP.
- RD_ADDR: on arready, set arvalid=0 and rready=1, go to RD_DATA.
- RD_DATA: on rvalid&rready, latch rdata and rresp, set rready=0, go to RSP.
- RSP: rsp_valid=1 and held, with data/resp stable, until rsp_ready. Then go to IDLE with req_ready=1.
  - Back-to-back throughput: one transaction per at least 4 cycles.
- AXI rules:
  - A valid, once asserted, is never deasserted before its ready.
  - Valids never wait on readies.
  - bvalid/rvalid arriving while the FSM is not waiting for them are not accepted (bready/rready=0).
- A ready that arrives in the same cycle valid first rises completes that handshake.

Optional Feature:
Macro CMD_QUEUE_AXIL_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to WR_RESP/RD_DATA and increments each waiting cycle.
  - At C_TIMEOUT_CYCLES, go to RSP with rsp_resp=2'b10, rsp_rdata=0, rsp_timeout=1, and set the sticky flag stale_pending (B or R per the aborted type).
  - While stale_pending: req_ready=0 in IDLE, and bready/rready is held 1 to drain exactly one stale beat silently, which clears the flag.
  - Address/data phases are never timed out, to preserve AXI valid stability.
- Without the macro: no counter, rsp_timeout=0, waits are unbounded.

Decomposition:
Package cmd_queue_axil_initiator_pkg holds:
- state enum typedef
- AXI resp localparams: OKAY=2'b00, SLVERR=2'b10
- request struct typedef {write, addr, wdata, wstrb}

No sub-module is needed. The timeout counter stays inline under the macro.

Test Plan:
- Write 0x0000_00A5 to addr 0x010, wstrb 4'hF, awready/wready both high at once → awaddr=0x010 one cycle after accept; rsp_valid with rsp_resp=00, rsp_rdata=0.
- Write with awready delayed 3 cycles and wready immediate → wvalid drops first, awvalid held 3 cycles, single bresp reported.
- Read addr 0x004, slave returns rdata=0xDEAD_BEEF, rresp=00 after 5 cycles → rsp_rdata=0xDEADBEEF. With rsp_ready low 4 cycles, outputs stay stable and req_ready=0.
- Slave returns bresp=2'b10 → rsp_resp=10, no retry.
- Assert aresetn low during RD_DATA → all valids/readies 0 asynchronously, no rsp_valid after release, next request handled normally.
- (TIMEOUT_EN, C_TIMEOUT_CYCLES=16) slave withholds rvalid → rsp_resp=10 and rsp_timeout=1 at cycle 16. Late rvalid is drained with rready=1 and no rsp. Then req_ready returns to 1.

Source files
------------

// File: rtl/cmd_queue_axil_initiator_pkg.sv
// Shared types for the AXI4-Lite command-queue initiator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cmd_queue_axil_initiator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RSP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // The address field is sized for the widest supported AXI address (32 bits);
  // the initiator uses only the low C_ADDR_WIDTH bits.
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

endpackage

// File: rtl/cmd_queue_axil_initiator.sv
// Single-outstanding AXI4-Lite master driven by a valid/ready request port.
// Latency: request accept to AXI valid is 1 cycle; one transaction per >=4 cycles.
// Backpressure: req_ready low while busy; rsp_valid held until rsp_ready.
//
// Ports: aclk/aresetn (async active-low); req_* request in; rsp_* response out;
// m_axi_* AXI4-Lite master (32-bit data, prot tied 0).
// Build option CMD_QUEUE_AXIL_TIMEOUT_EN: bounds the B/R wait to C_TIMEOUT_CYCLES,
// synthesises a SLVERR response and silently drains the one late beat.
module cmd_queue_axil_initiator
  import cmd_queue_axil_initiator_pkg::*;
#(
  parameter int C_ADDR_WIDTH     = 12,
  parameter int C_TIMEOUT_CYCLES = 1024
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [C_ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]             req_wdata,
  input  logic [3:0]              req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [C_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [31:0]             m_axi_wdata,
  output logic [3:0]              m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [C_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [31:0]             m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  state_t state;
  req_t   req_in;
  req_t   req_q;
  logic   aw_done;
  logic   w_done;
  logic   aw_now;
  logic   w_now;
  logic   stale_any;

  // Word-align at capture so the AXI address outputs come straight from req_q.
  assign req_in = '{write: req_write,
                    addr:  32'({req_addr[C_ADDR_WIDTH-1:2], 2'b00}),
                    wdata: req_wdata,
                    wstrb: req_wstrb};

  assign m_axi_awaddr = req_q.addr[C_ADDR_WIDTH-1:0];
  assign m_axi_araddr = req_q.addr[C_ADDR_WIDTH-1:0];
  assign m_axi_wdata  = req_q.wdata;
  assign m_axi_wstrb  = req_q.wstrb;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

  // A phase is finished if it completed earlier or completes this cycle.
  assign aw_now = aw_done | (m_axi_awvalid & m_axi_awready);
  assign w_now  = w_done  | (m_axi_wvalid  & m_axi_wready);

  logic unused_bits;
  assign unused_bits = ^{req_q, req_addr[1:0]};

`ifdef CMD_QUEUE_AXIL_TIMEOUT_EN
  localparam int CNT_W = $clog2(C_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(C_TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             stale_b;
  logic             stale_r;
  assign stale_any = stale_b | stale_r;
`else
  localparam int unused_tmo_cycles = C_TIMEOUT_CYCLES;
  assign stale_any   = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= ST_IDLE;
      req_q         <= '0;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= RESP_OKAY;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
`ifdef CMD_QUEUE_AXIL_TIMEOUT_EN
      tmo_cnt       <= '0;
      stale_b       <= 1'b0;
      stale_r       <= 1'b0;
      rsp_timeout   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_q     <= req_in;
            req_ready <= 1'b0;
            if (req_write) begin
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              state         <= ST_WR_ADDR;
            end else begin
              m_axi_arvalid <= 1'b1;
              state         <= ST_RD_ADDR;
            end
          end else begin
            // Stays closed until a stale beat from a timed-out transfer drains.
            req_ready <= !stale_any;
          end
        end
        ST_WR_ADDR: begin
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          aw_done <= aw_now;
          w_done  <= w_now;
          if (aw_now && w_now) begin
            m_axi_bready <= 1'b1;
            state        <= ST_WR_RESP;
`ifdef CMD_QUEUE_AXIL_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
          end
        end
        ST_WR_RESP: begin
          if (m_axi_bvalid && m_axi_bready) begin
            rsp_resp     <= m_axi_bresp;
            rsp_rdata    <= '0;
            m_axi_bready <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= ST_RSP;
`ifdef CMD_QUEUE_AXIL_TIMEOUT_EN
            rsp_timeout  <= 1'b0;
          end else if (tmo_cnt == TMO_LAST) begin
            // bready stays high so the late B beat is absorbed.
            rsp_resp    <= RESP_SLVERR;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b1;
            stale_b     <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= ST_RSP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
`endif
          end
        end
        ST_RD_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= ST_RD_DATA;
`ifdef CMD_QUEUE_AXIL_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
          end
        end
        ST_RD_DATA: begin
          if (m_axi_rvalid && m_axi_rready) begin
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            m_axi_rready <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= ST_RSP;
`ifdef CMD_QUEUE_AXIL_TIMEOUT_EN
            rsp_timeout  <= 1'b0;
          end else if (tmo_cnt == TMO_LAST) begin
            rsp_resp    <= RESP_SLVERR;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b1;
            stale_r     <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= ST_RSP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
`endif
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= !stale_any;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
`ifdef CMD_QUEUE_AXIL_TIMEOUT_EN
      // Swallow exactly one late beat from an aborted transfer, no response.
      if (stale_b && m_axi_bvalid && m_axi_bready) begin
        stale_b      <= 1'b0;
        m_axi_bready <= 1'b0;
      end
      if (stale_r && m_axi_rvalid && m_axi_rready) begin
        stale_r      <= 1'b0;
        m_axi_rready <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_cmd_queue_axil_initiator.sv
// Scoreboard bench for cmd_queue_axil_initiator with a scripted AXI4-Lite slave.
// Latency: checks 1-cycle request-to-valid and, with the timeout build, the wait bound.
// Backpressure: exercises delayed ready/valid on every AXI channel and rsp_ready stalls.
module tb_cmd_queue_axil_initiator;

  localparam int AW  = 12;
  localparam int TMO = 16;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        tmo;
  } exp_t;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic [3:0]    req_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          awvalid;
  logic          awready = 1'b0;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready = 1'b0;
  logic [1:0]    bresp = 2'b00;
  logic          bvalid = 1'b0;
  logic          bready;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [31:0]   rdata = '0;
  logic [1:0]    rresp = 2'b00;
  logic          rvalid = 1'b0;
  logic          rready;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 aclk = ~aclk;

  cmd_queue_axil_initiator #(.C_ADDR_WIDTH(AW), .C_TIMEOUT_CYCLES(TMO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
    .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Response monitor: every accepted response must match the oldest expectation.
  always @(negedge aclk) begin
    if (aresetn && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("rsp_rdata", rsp_rdata, e.rdata);
        check_eq("rsp_resp", {30'd0, rsp_resp}, {30'd0, e.resp});
        check_eq("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.tmo});
      end
    end
  end

  // Presents one request and returns at the negedge after it was accepted.
  task automatic send_req(input logic w, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge aclk);
    req_write = w; req_addr = a; req_wdata = d; req_wstrb = s; req_valid = 1'b1;
    for (n = 0; n < 100 && !req_ready; n++) @(negedge aclk);
    check_eq("req_ready_wait", {31'd0, req_ready}, 32'd1);
    @(posedge aclk); #1;
    req_valid = 1'b0;
    @(negedge aclk);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly,
                          input logic [1:0] br);
    int n;
    exp_q.push_back('{rdata: 32'd0, resp: br, tmo: 1'b0});
    send_req(1'b1, a, d, s);
    check_eq("awvalid_lat1", {31'd0, awvalid}, 32'd1);
    check_eq("wvalid_lat1", {31'd0, wvalid}, 32'd1);
    check_eq("awaddr", {20'd0, awaddr}, {20'd0, a[AW-1:2], 2'b00});
    check_eq("wdata", wdata, d);
    check_eq("wstrb", {28'd0, wstrb}, {28'd0, s});
    fork
      begin
        for (int i = 0; i < aw_dly; i++) begin
          check_eq("awvalid_held", {31'd0, awvalid}, 32'd1);
          @(negedge aclk);
        end
        awready = 1'b1;
        @(posedge aclk); #1;
        awready = 1'b0;
        @(negedge aclk);
        check_eq("awvalid_drop", {31'd0, awvalid}, 32'd0);
      end
      begin
        for (int i = 0; i < w_dly; i++) begin
          check_eq("wvalid_held", {31'd0, wvalid}, 32'd1);
          @(negedge aclk);
        end
        wready = 1'b1;
        @(posedge aclk); #1;
        wready = 1'b0;
        @(negedge aclk);
        check_eq("wvalid_drop", {31'd0, wvalid}, 32'd0);
        if (aw_dly > w_dly + 1) check_eq("awvalid_after_w", {31'd0, awvalid}, 32'd1);
      end
    join
    for (n = 0; n < 100 && !bready; n++) @(negedge aclk);
    check_eq("bready_wait", {31'd0, bready}, 32'd1);
    repeat (b_dly) @(negedge aclk);
    bvalid = 1'b1; bresp = br;
    @(posedge aclk); #1;
    bvalid = 1'b0; bresp = 2'b00;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int ar_dly, input int r_dly,
                         input logic [31:0] rd, input logic [1:0] rr);
    int n;
    exp_q.push_back('{rdata: rd, resp: rr, tmo: 1'b0});
    send_req(1'b0, a, 32'd0, 4'h0);
    check_eq("arvalid_lat1", {31'd0, arvalid}, 32'd1);
    check_eq("araddr", {20'd0, araddr}, {20'd0, a[AW-1:2], 2'b00});
    for (int i = 0; i < ar_dly; i++) begin
      check_eq("arvalid_held", {31'd0, arvalid}, 32'd1);
      @(negedge aclk);
    end
    arready = 1'b1;
    @(posedge aclk); #1;
    arready = 1'b0;
    @(negedge aclk);
    check_eq("arvalid_drop", {31'd0, arvalid}, 32'd0);
    for (n = 0; n < 100 && !rready; n++) @(negedge aclk);
    check_eq("rready_wait", {31'd0, rready}, 32'd1);
    repeat (r_dly) @(negedge aclk);
    rvalid = 1'b1; rdata = rd; rresp = rr;
    @(posedge aclk); #1;
    rvalid = 1'b0; rdata = '0; rresp = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got 1 exp 0");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset values.
    repeat (2) @(negedge aclk);
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_valids", {26'd0, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 32'd0);
    check_eq("rst_rsp", {rsp_rdata[29:0], rsp_resp}, 32'd0);
    aresetn = 1'b1;

    // Aligned write, both readies immediately.
    do_write(12'h010, 32'h0000_00A5, 4'hF, 0, 0, 0, 2'b00);
    // awready late, wready immediate: W finishes first.
    do_write(12'h020, 32'h1234_5678, 4'h3, 3, 0, 2, 2'b00);
    // Unaligned address: low bits are zeroed; slave reports SLVERR.
    do_write(12'h037, 32'hCAFE_F00D, 4'h8, 0, 2, 0, 2'b10);
    repeat (3) begin
      @(negedge aclk);
      check_eq("no_retry", {31'd0, awvalid}, 32'd0);
    end

    // Read with slow R and a stalled consumer.
    rsp_ready = 1'b0;
    do_read(12'h004, 1, 5, 32'hDEAD_BEEF, 2'b00);
    for (n = 0; n < 100 && !rsp_valid; n++) @(negedge aclk);
    for (int i = 0; i < 4; i++) begin
      check_eq("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("stall_rdata", rsp_rdata, 32'hDEAD_BEEF);
      check_eq("stall_req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge aclk);
    end
    @(posedge aclk); #1;
    rsp_ready = 1'b1;

    // Read returning SLVERR.
    do_read(12'h0FC, 0, 0, 32'h0BAD_0BAD, 2'b10);

    // Reset while waiting in RD_DATA: everything drops, no response later.
    send_req(1'b0, 12'h008, 32'd0, 4'h0);
    arready = 1'b1;
    @(posedge aclk); #1;
    arready = 1'b0;
    @(negedge aclk);
    check_eq("pre_rst_rready", {31'd0, rready}, 32'd1);
    #2 aresetn = 1'b0;
    #1;
    check_eq("async_rst_valids", {26'd0, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 32'd0);
    check_eq("async_rst_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check_eq("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    do_read(12'h00C, 0, 1, 32'h5A5A_0001, 2'b00);

`ifdef CMD_QUEUE_AXIL_TIMEOUT_EN
    // Slave withholds R: synthesised SLVERR after TMO cycles, late beat drained.
    exp_q.push_back('{rdata: 32'd0, resp: 2'b10, tmo: 1'b1});
    send_req(1'b0, 12'h018, 32'd0, 4'h0);
    arready = 1'b1;
    @(posedge aclk); #1;
    arready = 1'b0;
    for (n = 0; n < 100 && !rsp_valid; n++) begin
      @(posedge aclk); #1;
    end
    check_eq("timeout_cycles", n, TMO);
    repeat (3) @(negedge aclk);
    check_eq("stale_rready", {31'd0, rready}, 32'd1);
    check_eq("stale_req_ready", {31'd0, req_ready}, 32'd0);
    rvalid = 1'b1; rdata = 32'h7777_7777;
    @(posedge aclk); #1;
    rvalid = 1'b0; rdata = '0;
    @(negedge aclk);
    check_eq("drained_rready", {31'd0, rready}, 32'd0);
    repeat (2) @(negedge aclk);
    check_eq("drained_req_ready", {31'd0, req_ready}, 32'd1);
    do_read(12'h01C, 0, 0, 32'h0000_1234, 2'b00);
`endif

    repeat (5) @(negedge aclk);
    check_eq("sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
